// File: rtl/udp_tx_buf.sv
// udp_tx_buf: stores one UDP payload frame, counts its bytes and builds its
// one's-complement sum, then asks eth_tx for a header and streams the frame.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid_i       application word valid
//   in_data_i        payload word, byte 0 in [7:0] and first on the wire
//   in_keep_i        contiguous valid-byte mask for in_data_i
//   in_last_i        final word of the frame
//   in_cancel_i      abort the frame being filled
//   in_ready_o       a word is accepted this cycle when in_valid_i is high
//   ovf_o            one-cycle pulse: frame dropped, it did not fit the store
//   app_early_v_o    header request towards eth_tx
//   app_ready_v_i    eth_tx took the header, payload may start
//   app_valid_o      payload word valid (no backpressure)
//   app_last_o       final payload word
//   app_data_o       payload word
//   app_len_o        byte mask for app_data_o
//   app_pkt_len_o    payload byte count of the buffered frame
//   app_cs_o         one's-complement payload sum, not inverted
module udp_tx_buf #(
   parameter  int DATA_W    = 16,
   parameter  int PKT_LEN_W = 16,
   parameter  int BUF_WORDS = 736,
   localparam int KEEP_W    = DATA_W / 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid_i,
   input  logic [DATA_W-1:0]    in_data_i,
   input  logic [KEEP_W-1:0]    in_keep_i,
   input  logic                 in_last_i,
   input  logic                 in_cancel_i,
   output logic                 in_ready_o,
   output logic                 ovf_o,
   output logic                 app_early_v_o,
   input  logic                 app_ready_v_i,
   output logic                 app_valid_o,
   output logic                 app_last_o,
   output logic [DATA_W-1:0]    app_data_o,
   output logic [KEEP_W-1:0]    app_len_o,
   output logic [PKT_LEN_W-1:0] app_pkt_len_o,
   output logic [15:0]          app_cs_o
);

   localparam int AW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
   localparam int CW = $clog2(BUF_WORDS + 1);
   localparam int NT = (KEEP_W + 1) / 2;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      DROP,
      REQ,
      SEND
   } state_t;

   state_t                state_q;
   logic [DATA_W-1:0]     mem_q [BUF_WORDS];
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         cnt_d;
   logic [CW-1:0]         rd_q;
   logic [KEEP_W-1:0]     last_keep_q;
   logic [PKT_LEN_W-1:0]  len_acc_q;
   logic [PKT_LEN_W-1:0]  len_d;
   logic [15:0]           cs_acc_q;
   logic [15:0]           cs_d;

   logic                  in_ready_q;
   logic                  ovf_q;
   logic                  early_q;
   logic                  valid_q;
   logic                  last_q;
   logic [DATA_W-1:0]     data_q;
   logic [KEEP_W-1:0]     keep_q;
   logic [PKT_LEN_W-1:0]  pkt_len_q;
   logic [15:0]           cs_q;

   logic                  acc;
   logic                  full;
   logic                  store;
   logic [AW-1:0]         wr_a;
   logic [AW-1:0]         rd_a;
   logic                  rd_last;
   logic [KEEP_W-1:0]     rd_keep;

   function automatic logic [PKT_LEN_W-1:0] popcnt(
      input logic [KEEP_W-1:0] k
   );
      logic [PKT_LEN_W-1:0] n;
      n = '0;
      for (int i = 0; i < KEEP_W; i++)
         n = n + PKT_LEN_W'(k[i]);
      return n;
   endfunction

   // Byte 0 of each pair is the high half of its 16-bit term. Masked bytes
   // (and the pad byte of an odd-width bus) contribute zero. Two folds bring
   // any 32-bit partial sum back into 16 bits with end-around carry.
   function automatic logic [15:0] cs_add(
      input logic [15:0]       a,
      input logic [DATA_W-1:0] d,
      input logic [KEEP_W-1:0] k
   );
      logic [NT*16-1:0] pd;
      logic [31:0]      s;
      pd = '0;
      for (int i = 0; i < KEEP_W; i++)
         if (k[i]) pd[i*8 +: 8] = d[i*8 +: 8];
      s = {16'd0, a};
      for (int t = 0; t < NT; t++)
         s = s + {16'd0, pd[t*16 +: 8], pd[t*16+8 +: 8]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return s[15:0];
   endfunction

   assign acc  = in_valid_i & in_ready_q;
   assign full = (cnt_q == CW'(BUF_WORDS));

   // A word is kept when it opens a frame, or extends one that still fits.
   assign store = acc & ((state_q == IDLE) |
                  ((state_q == FILL) & ~in_cancel_i & ~full));

   assign wr_a    = (state_q == IDLE) ? '0 : cnt_q[AW-1:0];
   assign rd_a    = rd_q[AW-1:0];
   assign rd_last = (rd_q == cnt_q - CW'(1));
   assign rd_keep = rd_last ? last_keep_q : {KEEP_W{1'b1}};

   always_comb begin
      cnt_d = CW'(1);
      len_d = popcnt(in_keep_i);
      cs_d  = cs_add(16'h0000, in_data_i, in_keep_i);
      if (state_q != IDLE) begin
         cnt_d = cnt_q + CW'(1);
         len_d = len_acc_q + popcnt(in_keep_i);
         cs_d  = cs_add(cs_acc_q, in_data_i, in_keep_i);
      end
   end

   always_ff @(posedge clk) begin
      if (store && !reset)
         mem_q[wr_a] <= in_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rd_q        <= '0;
         last_keep_q <= '0;
         len_acc_q   <= '0;
         cs_acc_q    <= '0;
         in_ready_q  <= 1'b0;
         ovf_q       <= 1'b0;
         early_q     <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         data_q      <= '0;
         keep_q      <= '0;
         pkt_len_q   <= '0;
         cs_q        <= '0;
      end else begin
         in_ready_q <= 1'b1;
         ovf_q      <= 1'b0;
         if (store) begin
            cnt_q       <= cnt_d;
            len_acc_q   <= len_d;
            cs_acc_q    <= cs_d;
            last_keep_q <= in_keep_i;
            if (in_last_i) begin
               state_q    <= REQ;
               in_ready_q <= 1'b0;
               early_q    <= 1'b1;
               pkt_len_q  <= len_d;
               cs_q       <= cs_d;
            end else begin
               state_q <= FILL;
            end
         end else begin
            unique case (state_q)
               IDLE: ;
               // In FILL an accepted word that is not stored overflowed.
               FILL, DROP: begin
                  if (in_cancel_i) begin
                     state_q <= IDLE;
                  end else if (acc) begin
                     if (in_last_i) begin
                        state_q <= IDLE;
                        ovf_q   <= 1'b1;
                     end else begin
                        state_q <= DROP;
                     end
                  end
               end
               REQ: begin
                  in_ready_q <= 1'b0;
                  data_q     <= mem_q[rd_a];
                  if (app_ready_v_i) begin
                     state_q <= SEND;
                     early_q <= 1'b0;
                     valid_q <= 1'b1;
                     last_q  <= rd_last;
                     keep_q  <= rd_keep;
                     rd_q    <= rd_q + CW'(1);
                  end
               end
               SEND: begin
                  if (last_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     keep_q  <= '0;
                     rd_q    <= '0;
                  end else begin
                     in_ready_q <= 1'b0;
                     data_q     <= mem_q[rd_a];
                     last_q     <= rd_last;
                     keep_q     <= rd_keep;
                     rd_q       <= rd_q + CW'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign in_ready_o    = in_ready_q;
   assign ovf_o         = ovf_q;
   assign app_early_v_o = early_q;
   assign app_valid_o   = valid_q;
   assign app_last_o    = last_q;
   assign app_data_o    = data_q;
   assign app_len_o     = keep_q;
   assign app_pkt_len_o = pkt_len_q;
   assign app_cs_o      = cs_q;

endmodule

// File: tb/tb_udp_tx_buf.sv
// tb_udp_tx_buf: frame-level bench for udp_tx_buf, one full-size and one
// 8-word instance, checked against a byte-queue reference model.
module tb_udp_tx_buf;

   localparam int BIG   = 736;
   localparam int SMALL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        in_valid;
   logic [15:0] in_data;
   logic [1:0]  in_keep;
   logic        in_last;
   logic        in_cancel;
   logic        app_rdy_v;

   logic        b_rdy, b_ovf, b_early, b_valid, b_last;
   logic [15:0] b_data, b_plen, b_cs;
   logic [1:0]  b_len;
   logic        s_rdy, s_ovf, s_early, s_valid, s_last;
   logic [15:0] s_data, s_plen, s_cs;
   logic [1:0]  s_len;

   udp_tx_buf u_big (
      .clk           (clk),
      .reset         (reset),
      .in_valid_i    (in_valid & ~sel),
      .in_data_i     (in_data),
      .in_keep_i     (in_keep),
      .in_last_i     (in_last),
      .in_cancel_i   (in_cancel & ~sel),
      .in_ready_o    (b_rdy),
      .ovf_o         (b_ovf),
      .app_early_v_o (b_early),
      .app_ready_v_i (app_rdy_v & ~sel),
      .app_valid_o   (b_valid),
      .app_last_o    (b_last),
      .app_data_o    (b_data),
      .app_len_o     (b_len),
      .app_pkt_len_o (b_plen),
      .app_cs_o      (b_cs)
   );

   udp_tx_buf #(.BUF_WORDS(SMALL)) u_small (
      .clk           (clk),
      .reset         (reset),
      .in_valid_i    (in_valid & sel),
      .in_data_i     (in_data),
      .in_keep_i     (in_keep),
      .in_last_i     (in_last),
      .in_cancel_i   (in_cancel & sel),
      .in_ready_o    (s_rdy),
      .ovf_o         (s_ovf),
      .app_early_v_o (s_early),
      .app_ready_v_i (app_rdy_v & sel),
      .app_valid_o   (s_valid),
      .app_last_o    (s_last),
      .app_data_o    (s_data),
      .app_len_o     (s_len),
      .app_pkt_len_o (s_plen),
      .app_cs_o      (s_cs)
   );

   logic        rdy, ovf, early, valid, last;
   logic [15:0] data, plen, cs;
   logic [1:0]  len;
   assign rdy   = sel ? s_rdy   : b_rdy;
   assign ovf   = sel ? s_ovf   : b_ovf;
   assign early = sel ? s_early : b_early;
   assign valid = sel ? s_valid : b_valid;
   assign last  = sel ? s_last  : b_last;
   assign data  = sel ? s_data  : b_data;
   assign plen  = sel ? s_plen  : b_plen;
   assign cs    = sel ? s_cs    : b_cs;
   assign len   = sel ? s_len   : b_len;

   int n_chk = 0;
   int n_err = 0;
   int early_cyc = 0;
   int ovf_cnt = 0;
   int stray = 0;

   logic [7:0] frm [$];

   always @(negedge clk) begin
      if (early === 1'b1) early_cyc++;
      if (ovf === 1'b1) ovf_cnt++;
      if ((sel ? (b_early | b_valid | b_ovf)
               : (s_early | s_valid | s_ovf)) === 1'b1)
         stray++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_cs();
      longint unsigned t;
      t = 0;
      for (int i = 0; i < frm.size(); i += 2) begin
         t += longint'(frm[i]) * 256;
         if (i + 1 < frm.size()) t += longint'(frm[i+1]);
      end
      return (t == 0) ? 16'h0 : 16'(((t - 1) % 65535) + 1);
   endfunction

   task automatic rand_frame(input int nb);
      frm = {};
      for (int i = 0; i < nb; i++) frm.push_back(8'($urandom));
   endtask

   task automatic drive_word(input logic [15:0] d, input logic [1:0] k,
                             input logic l, input logic c);
      int n;
      n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_keep   = k;
      in_last   = l;
      in_cancel = c;
      @(negedge clk);
      while (!rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", rdy, 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_cancel = 1'b0;
      in_data   = 16'($urandom);
      in_keep   = 2'($urandom);
      in_last   = 1'($urandom);
   endtask

   task automatic send_frame(input int cancel_at);
      int nw;
      logic [15:0] d;
      logic [1:0] k;
      nw = (frm.size() + 1) / 2;
      for (int w = 0; w < nw; w++) begin
         d[7:0] = frm[2*w];
         if (2*w + 1 < frm.size()) begin
            d[15:8] = frm[2*w+1];
            k = 2'b11;
         end else begin
            d[15:8] = 8'($urandom);
            k = 2'b01;
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         drive_word(d, k, w == nw - 1, w == cancel_at);
         if (w == cancel_at) break;
      end
   endtask

   task automatic recv_frame(input int hold);
      int n, nb, nw;
      logic [15:0] ecs;
      bit odd;
      n   = 0;
      nb  = frm.size();
      nw  = (nb + 1) / 2;
      ecs = model_cs();
      @(negedge clk);
      while (!early && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("early_v", early, 1);
      chk("pkt_len", plen, nb);
      chk("cs", cs, ecs);
      chk("req_in_ready", rdy, 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_early", early, 1);
         chk("hold_in_ready", rdy, 0);
         chk("hold_valid", valid, 0);
      end
      @(posedge clk); #1;
      app_rdy_v = 1'b1;
      @(negedge clk);
      chk("rdy_cyc_valid", valid, 0);
      chk("rdy_cyc_early", early, 1);
      @(posedge clk); #1;
      app_rdy_v = 1'($urandom);
      for (int w = 0; w < nw; w++) begin
         odd = (2*w + 1 >= nb);
         @(negedge clk);
         chk("app_valid", valid, 1);
         chk("early_drop", early, 0);
         chk("send_in_ready", rdy, 0);
         chk("data_lo", data[7:0], frm[2*w]);
         if (!odd) chk("data_hi", data[15:8], frm[2*w+1]);
         chk("app_len", len, odd ? 2'b01 : 2'b11);
         chk("app_last", last, w == nw - 1);
         @(posedge clk); #1;
      end
      app_rdy_v = 1'b0;
      @(negedge clk);
      chk("post_valid", valid, 0);
      chk("post_last", last, 0);
      chk("post_in_ready", rdy, 1);
      chk("keep_pkt_len", plen, nb);
      chk("keep_cs", cs, ecs);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int cancel_at, input int hold);
      int nw, bufw, e0, o0;
      nw   = (frm.size() + 1) / 2;
      bufw = sel ? SMALL : BIG;
      e0   = early_cyc;
      o0   = ovf_cnt;
      send_frame(cancel_at);
      if (cancel_at >= 0) begin
         repeat (4) begin @(posedge clk); #1; end
         chk("cancel_no_early", early_cyc - e0, 0);
         chk("cancel_no_ovf", ovf_cnt - o0, 0);
         chk("cancel_in_ready", rdy, 1);
      end else if (nw > bufw) begin
         @(negedge clk);
         chk("ovf_pulse", ovf, 1);
         repeat (4) begin @(posedge clk); #1; end
         chk("ovf_once", ovf_cnt - o0, 1);
         chk("ovf_no_early", early_cyc - e0, 0);
         chk("ovf_in_ready", rdy, 1);
      end else begin
         recv_frame(hold);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int nb, nw, ca;
      reset     = 1'b1;
      sel       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_keep   = '0;
      in_last   = 1'b0;
      in_cancel = 1'b0;
      app_rdy_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", b_rdy, 0);
      chk("rst_early", b_early, 0);
      chk("rst_valid", b_valid, 0);
      chk("rst_ovf", b_ovf, 0);
      chk("rst_pkt_len", b_plen, 0);
      chk("rst_cs", b_cs, 0);
      chk("rst_s_in_ready", s_rdy, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", b_rdy, 1);
      chk("post_rst_s_ready", s_rdy, 1);

      frm = {};
      for (int i = 1; i <= 19; i++) frm.push_back(8'(i));
      chk("model_cs_19", model_cs(), 16'h645A);
      run_frame(-1, 2);

      frm = {};
      frm.push_back(8'hFF);
      frm.push_back(8'hFF);
      frm.push_back(8'h00);
      frm.push_back(8'h02);
      run_frame(-1, 0);

      rand_frame(6);
      run_frame(-1, 5);

      rand_frame(10);
      run_frame(2, 0);
      rand_frame(2);
      run_frame(-1, 1);

      rand_frame(1);
      run_frame(-1, 0);

      sel = 1'b1;
      rand_frame(20);
      run_frame(-1, 0);
      rand_frame(16);
      run_frame(-1, 1);
      rand_frame(17);
      run_frame(-1, 0);
      rand_frame(24);
      run_frame(9, 0);
      rand_frame(3);
      run_frame(-1, 0);

      for (int it = 0; it < 40; it++) begin
         sel = 1'($urandom);
         nb  = $urandom_range(1, sel ? 22 : 40);
         nw  = (nb + 1) / 2;
         ca  = -1;
         if (nw >= 2 && $urandom_range(0, 4) == 0)
            ca = $urandom_range(1, nw - 1);
         rand_frame(nb);
         run_frame(ca, $urandom_range(0, 3));
      end

      sel = 1'b0;
      rand_frame(10);
      send_frame(-1);
      @(negedge clk);
      chk("r43_early", early, 1);
      @(posedge clk); #1;
      app_rdy_v = 1'b1;
      @(posedge clk); #1;
      app_rdy_v = 1'b0;
      @(negedge clk);
      chk("r43_send1", valid, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("r43_send2", valid, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("r43_valid", valid, 0);
      chk("r43_last", last, 0);
      chk("r43_early0", early, 0);
      chk("r43_in_ready0", rdy, 0);
      chk("r43_ovf", ovf, 0);
      chk("r43_data", data, 0);
      chk("r43_len", len, 0);
      chk("r43_pkt_len", plen, 0);
      chk("r43_cs", cs, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("r43_in_ready1", rdy, 1);
      repeat (4) begin
         @(negedge clk);
         chk("r43_no_words", valid, 0);
      end
      @(posedge clk); #1;
      rand_frame(5);
      run_frame(-1, 1);

      chk("idle_dut_quiet", stray, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end

endmodule
